spi_coeff_loader: RTL

- SPI slave (mode 0) that receives biquad coefficient frames from the MCU.
- Assembles five Q2.14 coefficients per frame into a per-band shadow bank.
- Copies pending banks into the active registers atomically on the audio sample strobe, so the low/mid/high filter instances never see a half-updated coefficient set.
- Sits between the MCU SPI pins and the three biquad filter instances.

---
 rtl/coeff_pkg.sv | 37 +++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_coeff_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/coeff_pkg.sv
// Shared types and constants for the SPI biquad coefficient loader.
package coeff_pkg;

    localparam int NUM_COEFF  = 5;
    localparam int HDR_BITS   = 8;
    localparam int DATA_BITS  = NUM_COEFF * 16;
    localparam int FRAME_BITS = HDR_BITS + DATA_BITS;

    localparam logic [1:0]  CMD_WRITE   = 2'b10;
    localparam logic [15:0] COEFF_UNITY = 16'h4000;

    typedef logic signed [15:0] coeff_t;

    typedef struct packed {
        coeff_t b0;
        coeff_t b1;
        coeff_t b2;
        coeff_t a1;
        coeff_t a2;
    } band_coeffs_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DONE,
        ST_DISCARD
    } state_t;

    function automatic band_coeffs_t unity_coeffs();
        band_coeffs_t c;
        c    = '0;
        c.b0 = COEFF_UNITY;
        return c;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a one-flop rise/fall pulse detector.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_coeff_loader.sv
// SPI mode-0 slave loading biquad coefficient frames into per-band shadow banks.
// Optional status readback on miso is enabled with SPI_COEFF_STATUS_EN.
module spi_coeff_loader
    import coeff_pkg::*;
#(
    parameter int NUM_BANDS   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    input  logic                         sample_strobe,
    output band_coeffs_t [NUM_BANDS-1:0] coeffs_o,
    output logic                         coeff_update,
    output logic                         frame_err
);

    localparam logic [2:0] NB = 3'(NUM_BANDS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Resets low so a frame already running at reset release is skipped.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .reset(reset), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_t                 state_q, state_d;
    logic [6:0]             cnt_q;
    logic [HDR_BITS-1:0]    hdr_q;
    logic [1:0]             band_q;
    logic [DATA_BITS-1:0]   stage_q;
    band_coeffs_t           shadow_q [NUM_BANDS];
    logic [NUM_BANDS-1:0]   pending_q;

    logic [HDR_BITS-1:0]    hdr_nxt;
    logic [DATA_BITS-1:0]   stage_nxt;
    logic                   hdr_ok;
    logic                   err_d;
    logic                   load;

    assign hdr_nxt   = {hdr_q[HDR_BITS-2:0], mosi_lvl};
    assign stage_nxt = {stage_q[DATA_BITS-2:0], mosi_lvl};
    assign hdr_ok    = (hdr_nxt[7:6] == CMD_WRITE)
                     && ({1'b0, hdr_nxt[5:4]} < NB);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load    = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            err_d   = (state_q == ST_HEADER) || (state_q == ST_DATA);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall)
                        state_d = ST_HEADER;
                end
                ST_HEADER: begin
                    if (sclk_rise && cnt_q == 7'(HDR_BITS - 1)) begin
                        if (hdr_ok) begin
                            state_d = ST_DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise && cnt_q == 7'(DATA_BITS - 1)) begin
                        load    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE, ST_DISCARD: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            hdr_q   <= '0;
            band_q  <= '0;
            stage_q <= '0;
        end else begin
            if (state_q != state_d)
                cnt_q <= '0;
            else if (sclk_rise && (state_q == ST_HEADER || state_q == ST_DATA))
                cnt_q <= cnt_q + 7'd1;
            if (sclk_rise && state_q == ST_HEADER) begin
                hdr_q  <= hdr_nxt;
                band_q <= hdr_nxt[5:4];
            end
            if (sclk_rise && state_q == ST_DATA)
                stage_q <= stage_nxt;
        end
    end

    // Commit uses the pending flags as they stood before this edge, so a
    // frame landing on the strobe cycle waits for the following strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow_q[b] <= unity_coeffs();
                coeffs_o[b] <= unity_coeffs();
            end
            pending_q    <= '0;
            coeff_update <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (sample_strobe && pending_q[b])
                    coeffs_o[b] <= shadow_q[b];
                if (load && band_q == 2'(b))
                    shadow_q[b] <= band_coeffs_t'(stage_nxt);
                pending_q[b] <= (load && band_q == 2'(b))
                              || (pending_q[b] && !sample_strobe);
            end
            coeff_update <= sample_strobe && (|pending_q);
            frame_err    <= err_d;
        end
    end

`ifdef SPI_COEFF_STATUS_EN
    logic       err_sticky;
    logic [7:0] st_sr;
    logic [3:0] st_cnt;
    logic [3:0] pend4;
    logic [7:0] status;
    logic       start_st;
    logic       unused_pend;

    assign pend4       = 4'(pending_q);
    assign unused_pend = pend4[3];
    assign status      = {1'b1, err_sticky, 3'b000, pend4[2:0]};
    assign start_st    = (state_q == ST_IDLE) && cs_fall && !cs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso       <= 1'b0;
            st_sr      <= '0;
            st_cnt     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (start_st) begin
                miso   <= status[7];
                st_sr  <= {status[6:0], 1'b0};
                st_cnt <= 4'd7;
            end else if (cs_rise) begin
                miso   <= 1'b0;
                st_cnt <= '0;
            end else if (sclk_fall) begin
                if (st_cnt != 4'd0) begin
                    miso   <= st_sr[7];
                    st_sr  <= {st_sr[6:0], 1'b0};
                    st_cnt <= st_cnt - 4'd1;
                end else begin
                    miso <= 1'b0;
                end
            end
            if (err_d)
                err_sticky <= 1'b1;
            else if (sclk_fall && !start_st && !cs_rise && st_cnt == 4'd1)
                err_sticky <= 1'b0;
        end
    end
`else
    assign miso = 1'b0;
`endif

endmodule
